// File: rtl/mem_hier_pkg.sv
// Shared types and width defaults for the mem_hier controller.
// Line storage is sized to the MAX_* widths so one struct type can hold
// any instance's tag and data; instances use only the low ADDR_W/DATA_W bits.
package mem_hier_pkg;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int NUM_LINES_DEF = 2;

  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 32;
  localparam int MAX_AGE_W  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [MAX_AGE_W-1:0]  age;
    logic [MAX_ADDR_W-1:0] tag;
    logic [MAX_DATA_W-1:0] data;
  } line_t;
endpackage

// File: rtl/mem_hier_lru.sv
// Age-counter LRU for the fully associative line array.
// Age 0 is MRU. On an access, the touched line goes to 0 and every line
// whose age is not above the touched line's old age ages by one
// (saturating). Invalid lines therefore always sit at or above every valid
// line, so valid lines keep a strict recency order.
module mem_hier_lru #(
  parameter int NUM_LINES = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_LINES-1:0]         valid,
  input  logic                         upd,
  input  logic [$clog2(NUM_LINES)-1:0] upd_idx,
  output logic [$clog2(NUM_LINES)-1:0] victim
);
  localparam int AGE_W = $clog2(NUM_LINES);

  logic [AGE_W-1:0] age_q [NUM_LINES];
  logic [AGE_W-1:0] max_age;
  logic             found;

  // age update: touched line becomes MRU
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= '0;
    end else if (upd) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (AGE_W'(i) == upd_idx)
          age_q[i] <= '0;
        else if (age_q[i] <= age_q[upd_idx] && age_q[i] != AGE_W'(NUM_LINES-1))
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // victim: lowest-index invalid line, else the oldest line
  always_comb begin
    victim  = '0;
    max_age = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (age_q[i] > max_age) begin
        max_age = age_q[i];
        victim  = AGE_W'(i);
      end
    end
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!found && !valid[i]) begin
        found  = 1'b1;
        victim = AGE_W'(i);
      end
    end
  end
endmodule

// File: rtl/mem_hier_ctrl.sv
// Single-level fully associative write-back cache controller.
// Optional: define MEM_HIER_STATS_EN to add saturating hit/miss/writeback
// counters on the ports hit_count, miss_count, wb_count.
module mem_hier_ctrl
  import mem_hier_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_LINES = NUM_LINES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_HIER_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
  output logic [15:0]       wb_count
`endif
);
  localparam int IDX_W = $clog2(NUM_LINES);

  state_t            state, nxt;
  line_t             lines_q [NUM_LINES];  // age field unused here: ages live in mem_hier_lru
  logic              we_q, hit_q, ready_en;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [IDX_W-1:0]  vic_q, victim, hit_idx, upd_idx;
  logic [NUM_LINES-1:0] valid_vec;
  logic              hit, vic_wb, upd;
  line_t             wr_line;

  // tag compare against every valid line
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    valid_vec = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      valid_vec[i] = lines_q[i].valid;
      if (lines_q[i].valid && lines_q[i].tag[ADDR_W-1:0] == addr_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign vic_wb  = lines_q[victim].valid && lines_q[victim].dirty;
  assign wr_line = '{valid: 1'b1, dirty: 1'b1, age: '0,
                     tag: MAX_ADDR_W'(addr_q), data: MAX_DATA_W'(wdata_q)};

  // MRU touch on every hit and every install
  always_comb begin
    upd     = 1'b0;
    upd_idx = vic_q;
    case (state)
      LOOKUP: begin
        upd     = hit || (we_q && !vic_wb);
        upd_idx = hit ? hit_idx : victim;
      end
      WRITEBACK: upd = ram_ack && we_q;
      REFILL:    upd = ram_ack;
      default:   upd = 1'b0;
    endcase
  end

  mem_hier_lru #(.NUM_LINES(NUM_LINES)) u_lru (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (valid_vec),
    .upd     (upd),
    .upd_idx (upd_idx),
    .victim  (victim)
  );

  // state register; ready_en holds ready low until the first clock after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= nxt;
      ready_en <= 1'b1;
    end
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (req && ready) nxt = LOOKUP;
      LOOKUP:    if (hit)          nxt = RESPOND;
                 else if (vic_wb)  nxt = WRITEBACK;
                 else              nxt = we_q ? RESPOND : REFILL;
      WRITEBACK: if (ram_ack)      nxt = we_q ? RESPOND : REFILL;
      REFILL:    if (ram_ack)      nxt = RESPOND;
      RESPOND:                     nxt = IDLE;
      default:                     nxt = IDLE;
    endcase
  end

  // outputs decoded from state so reset forces them low at once
  always_comb begin
    ready      = ready_en && state == IDLE;
    resp_valid = state == RESPOND;
    resp_hit   = state == RESPOND && hit_q;
    rdata      = (state == RESPOND && !we_q) ? rdata_q : '0;
    ram_req    = state == WRITEBACK || state == REFILL;
    ram_we     = state == WRITEBACK;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (state == WRITEBACK) begin
      ram_addr  = lines_q[vic_q].tag[ADDR_W-1:0];
      ram_wdata = lines_q[vic_q].data[DATA_W-1:0];
    end else if (state == REFILL) begin
      ram_addr  = addr_q;
    end
  end

  // request latch, line array and response data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      vic_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req && ready) begin
          we_q    <= we;
          addr_q  <= addr;
          wdata_q <= wdata;
        end
        LOOKUP: begin
          hit_q <= hit;
          vic_q <= victim;
          if (hit) begin
            if (we_q) begin
              lines_q[hit_idx].data  <= MAX_DATA_W'(wdata_q);
              lines_q[hit_idx].dirty <= 1'b1;
            end else begin
              rdata_q <= lines_q[hit_idx].data[DATA_W-1:0];
            end
          end else if (we_q && !vic_wb) begin
            lines_q[victim] <= wr_line;
          end
        end
        WRITEBACK: if (ram_ack && we_q) lines_q[vic_q] <= wr_line;
        REFILL: if (ram_ack) begin
          lines_q[vic_q] <= '{valid: 1'b1, dirty: 1'b0, age: '0,
                              tag: MAX_ADDR_W'(addr_q), data: MAX_DATA_W'(ram_rdata)};
          rdata_q        <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_HIER_STATS_EN
  // saturating event counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == RESPOND && hit_q && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (state == RESPOND && !hit_q && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
      if (state == WRITEBACK && ram_ack && wb_count != 16'hFFFF)
        wb_count <= wb_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_hier_ctrl.sv
// Scoreboard bench for mem_hier_ctrl: an address-level LRU cache model
// predicts responses and RAM transactions; a monitor and a RAM responder
// check the DUT independently of the stimulus.
module tb_mem_hier_ctrl;
  localparam int NL = 2;

  logic       clock = 0, reset_n = 0, req = 0, we = 0;
  logic [7:0] addr = 0, wdata = 0;
  logic       ready, resp_valid, resp_hit;
  logic [7:0] rdata;
  logic       ram_req, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic       ram_ack = 0;
  logic [7:0] ram_rdata = 0;
`ifdef MEM_HIER_STATS_EN
  logic [15:0] hit_count, miss_count, wb_count;
`endif

  int total = 0, bad = 0;
  int ram_delay = 1;

  typedef struct { bit hit; bit rd; logic [7:0] data; int lat; } resp_t;
  typedef struct { bit w; logic [7:0] a; logic [7:0] d; } ramx_t;

  resp_t      exp_q[$];
  ramx_t      ram_q[$];
  int         acc_q[$];
  logic [7:0] ram_mem [256];
  logic [7:0] m_mem   [256];
  logic [7:0] c_data  [int];
  bit         c_dirty [int];
  int         rec[$];   // cached addresses, least recent first

  mem_hier_ctrl dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .rdata(rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata)
`ifdef MEM_HIER_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // reference: fully associative LRU write-back cache, write-allocate
  task automatic model_req(input bit w, input logic [7:0] a, input logic [7:0] d);
    resp_t r;
    int    ai, pos, v;
    bit    wb;
    ai = int'(a); pos = -1; wb = 0;
    for (int i = 0; i < rec.size(); i++) if (rec[i] == ai) pos = i;
    r.rd  = !w;
    r.hit = (pos >= 0);
    if (pos >= 0) begin
      rec.delete(pos);
      if (w) begin c_data[ai] = d; c_dirty[ai] = 1; end
    end else begin
      if (rec.size() == NL) begin
        v = rec.pop_front();
        if (c_dirty[v]) begin
          wb = 1;
          ram_q.push_back('{1'b1, 8'(v), c_data[v]});
          m_mem[v] = c_data[v];
        end
        c_data.delete(v); c_dirty.delete(v);
      end
      if (w) begin c_data[ai] = d; c_dirty[ai] = 1; end
      else begin
        ram_q.push_back('{1'b0, a, 8'h00});
        c_data[ai] = m_mem[ai]; c_dirty[ai] = 0;
      end
    end
    rec.push_back(ai);
    r.data = c_data[ai];
    r.lat  = (r.hit || (w && !wb)) ? 2 : -1;
    exp_q.push_back(r);
  endtask

  task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (!ready && n < 300) begin @(posedge clock); #1; n++; end
    if (!ready) chk("ready_timeout", 0, 1);
    else begin
      req = 1; we = w; addr = a; wdata = d;
      model_req(w, a, d);
      @(posedge clock); #1;
      req = 0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(posedge clock); #1; n++; end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic rst_assert();
    reset_n = 0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ram_req", ram_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    exp_q.delete(); acc_q.delete(); ram_q.delete();
    rec.delete(); c_data.delete(); c_dirty.delete();
  endtask

  task automatic rst_release();
    @(negedge clock); #2;
    chk("rst_hold_ready", ready, 0);
    reset_n = 1;
    @(posedge clock); #1;
    chk("ready_after_rst", ready, 1);
  endtask

  task automatic full_reset();
    @(negedge clock); #2;
    rst_assert();
    repeat (2) @(posedge clock);
    rst_release();
  endtask

  // response monitor
  initial begin : mon
    int ncyc;
    ncyc = 0;
    forever begin
      @(negedge clock);
      ncyc++;
      if (req && ready) acc_q.push_back(ncyc);
      if (resp_valid) begin
        resp_t r;
        int    a;
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          r = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
          chk("resp_hit", resp_hit, r.hit);
          if (r.rd) chk("rdata", rdata, r.data);
          if (r.lat >= 0) chk("latency", ncyc - a, r.lat);
        end
      end
    end
  end

  // backing RAM: checks each transfer against the model and holds it for ram_delay cycles
  initial begin : ramr
    bit    busy, have_e;
    int    cnt;
    ramx_t e;
    busy = 0; have_e = 0; cnt = 0;
    forever begin
      @(negedge clock);
      if (ram_ack) begin ram_ack = 0; busy = 0; end
      if (ram_req) begin
        if (!busy) begin
          busy = 1; cnt = ram_delay;
          have_e = (ram_q.size() != 0);
          if (!have_e) chk("ram_unexpected", 1, 0);
          else e = ram_q.pop_front();
        end
        if (have_e) begin
          chk("ram_we", ram_we, e.w);
          chk("ram_addr", ram_addr, e.a);
          if (e.w) chk("ram_wdata", ram_wdata, e.d);
        end
        if (cnt == 0) begin
          ram_ack = 1;
          if (ram_we) ram_mem[ram_addr] = ram_wdata;
          else        ram_rdata = ram_mem[ram_addr];
        end else cnt--;
      end else busy = 0;
    end
  end

  initial begin : stim
    int n;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'($urandom);
      m_mem[i]   = ram_mem[i];
    end
    ram_mem[2] = 8'h01; m_mem[2] = 8'h01;

    #3;
    rst_assert();
    repeat (2) @(posedge clock);
    rst_release();

    // write then read hit
    ram_delay = 1;
    do_req(1, 8'h00, 8'h05);
    do_req(0, 8'h00, 8'h00);
    wait_idle();

    // cold read miss
    full_reset();
    do_req(0, 8'h02, 8'h00);
    wait_idle();

    // dirty eviction of the LRU line
    full_reset();
    do_req(1, 8'h00, 8'hAA);
    do_req(1, 8'h01, 8'hBB);
    do_req(0, 8'h00, 8'h00);
    do_req(0, 8'h03, 8'h00);
    wait_idle();
`ifdef MEM_HIER_STATS_EN
    chk("hit_count", hit_count, 1);
    chk("miss_count", miss_count, 3);
    chk("wb_count", wb_count, 1);
`endif

    // stalled writeback + refill; requests while busy are ignored
    ram_delay = 5;
    do_req(0, 8'h04, 8'h00);
    for (int i = 0; i < 8; i++) begin
      req = 1; we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      chk("stall_ready", ready, 0);
      @(posedge clock); #1;
    end
    req = 0;
    wait_idle();

    // reset in the second REFILL cycle abandons the transfer
    full_reset();
    ram_delay = 20;
    do_req(0, 8'h02, 8'h00);
    n = 0;
    while (!ram_req && n < 50) begin @(posedge clock); #1; n++; end
    chk("refill_start", ram_req, 1);
    @(posedge clock); #2;
    rst_assert();
    repeat (2) @(posedge clock);
    rst_release();
    ram_delay = 1;
    do_req(0, 8'h02, 8'h00);
    wait_idle();

    // randomized traffic over a small address set
    for (int k = 0; k < 200; k++) begin
      ram_delay = $urandom_range(0, 3);
      do_req(1'($urandom), 8'($urandom_range(0, 5)), 8'($urandom));
    end
    wait_idle();
    chk("ram_left", ram_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
